// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store bus controller for the 512x8 byte-addressed RAM.
// Captures one request, checks alignment, drives the RAM until done (or timeout),
// extends load data and returns a one-cycle completion pulse qualified by fault.
module mem_access_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        rw,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [8:0]  addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        mfc,
    output logic        fault,
    output logic [31:0] rdata,
    output logic        ram_enable,
    output logic        ram_rw,
    output logic [8:0]  ram_address,
    output logic [1:0]  ram_mas,
    output logic [1:0]  ram_a,
    output logic [31:0] ram_din,
    input  logic [31:0] ram_dout,
    input  logic        ram_done
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rw_q, rw_d;
    logic [1:0]       size_q, size_d;
    logic             sext_q, sext_d;
    logic [8:0]       addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             busy_q, busy_d;
    logic             mfc_q, mfc_d;
    logic             fault_q, fault_d;
    logic             en_q, en_d;
    logic [31:0]      rdata_q, rdata_d;

    // Illegal size, or a halfword/word whose byte lane is not naturally aligned.
    function automatic logic access_bad(input logic [1:0] sz, input logic [1:0] lane);
        case (sz)
            2'b00:   return 1'b0;
            2'b01:   return lane[0];
            2'b10:   return lane != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    // Zero/sign extension of right-justified RAM data; words pass through untouched.
    function automatic logic [31:0] load_extend(input logic [31:0] dout, input logic [1:0] sz,
                                                input logic sx);
        case (sz)
            2'b00:   return {{24{sx & dout[7]}}, dout[7:0]};
            2'b01:   return {{16{sx & dout[15]}}, dout[15:0]};
            default: return dout;
        endcase
    endfunction

    // Next-state logic; outputs are derived from the next state so they register in step with it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        size_d  = size_q;
        sext_d  = sext_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        fault_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    rw_d    = rw;
                    size_d  = size;
                    sext_d  = sign_ext;
                    addr_d  = addr;
                    wdata_d = wdata;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (access_bad(size_q, addr_q[1:0])) begin
                    fault_d = 1'b1;
                    state_d = S_RESP;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // RAM done may still be stale from a previous access here, so it is not looked at.
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (ram_done) begin
                    if (rw_q) begin
                        rdata_d = load_extend(ram_dout, size_q, sext_q);
                    end
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    fault_d = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        en_d   = (state_d == S_ISSUE) || (state_d == S_WAIT);
        mfc_d  = (state_d == S_RESP);
        busy_d = (state_d != S_IDLE);
    end

    // State, holding registers and registered outputs; reset wins over every state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            size_q  <= 2'b00;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            mfc_q   <= 1'b0;
            fault_q <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            mfc_q   <= mfc_d;
            fault_q <= fault_d;
            en_q    <= en_d;
        end
    end

    assign busy        = busy_q;
    assign mfc         = mfc_q;
    assign fault       = fault_q;
    assign rdata       = rdata_q;
    assign ram_enable  = en_q;
    assign ram_rw      = rw_q;
    assign ram_address = {addr_q[8:2], 2'b00};
    assign ram_mas     = size_q;
    assign ram_a       = addr_q[1:0];
    assign ram_din     = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed plus randomized accesses against a byte-array reference model,
// with a behavioural RAM stub answering the controller's RAM port.
module tb_mem_access_ctrl;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        rw;
    logic [1:0]  size;
    logic        sign_ext;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic        busy;
    logic        mfc;
    logic        fault;
    logic [31:0] rdata;
    logic        ram_enable;
    logic        ram_rw;
    logic [8:0]  ram_address;
    logic [1:0]  ram_mas;
    logic [1:0]  ram_a;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;
    logic        ram_done;

    int n_checks = 0;
    int n_fail   = 0;

    // RAM stub storage and the reference model's view of memory
    byte unsigned ram_mem[512];
    byte unsigned model_mem[512];
    logic [31:0]  exp_rdata = 32'h0;
    int           stub_delay = 1;
    bit           stub_hang = 1'b0;
    int           st_cnt = 0;

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .rw          (rw),
        .size        (size),
        .sign_ext    (sign_ext),
        .addr        (addr),
        .wdata       (wdata),
        .busy        (busy),
        .mfc         (mfc),
        .fault       (fault),
        .rdata       (rdata),
        .ram_enable  (ram_enable),
        .ram_rw      (ram_rw),
        .ram_address (ram_address),
        .ram_mas     (ram_mas),
        .ram_a       (ram_a),
        .ram_din     (ram_din),
        .ram_dout    (ram_dout),
        .ram_done    (ram_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] stub_read(input int base, input int lane, input logic [1:0] mas);
        logic [31:0] r;
        int a;
        r = $urandom;
        a = base + lane;
        case (mas)
            2'b00:   return {r[31:8], ram_mem[a]};
            2'b01:   return {r[31:16], ram_mem[a+1], ram_mem[a]};
            default: return {ram_mem[base+3], ram_mem[base+2], ram_mem[base+1], ram_mem[base]};
        endcase
    endfunction

    // RAM stub: done after stub_delay enabled cycles; random stale done/data while disabled
    always @(posedge clk) begin
        if (!ram_enable) begin
            st_cnt   <= 0;
            ram_done <= 1'($urandom_range(0, 1));
            ram_dout <= $urandom;
        end else begin
            st_cnt <= st_cnt + 1;
            if (!stub_hang && (st_cnt + 1 >= stub_delay)) begin
                ram_done <= 1'b1;
                if (ram_rw) begin
                    ram_dout <= stub_read(int'(ram_address), int'(ram_a), ram_mas);
                end else begin
                    ram_dout <= $urandom;
                    case (ram_mas)
                        2'b00: ram_mem[int'(ram_address) + int'(ram_a)] <= ram_din[7:0];
                        2'b01: begin
                            ram_mem[int'(ram_address) + int'(ram_a)]     <= ram_din[7:0];
                            ram_mem[int'(ram_address) + int'(ram_a) + 1] <= ram_din[15:8];
                        end
                        default: begin
                            ram_mem[int'(ram_address)]     <= ram_din[7:0];
                            ram_mem[int'(ram_address) + 1] <= ram_din[15:8];
                            ram_mem[int'(ram_address) + 2] <= ram_din[23:16];
                            ram_mem[int'(ram_address) + 3] <= ram_din[31:24];
                        end
                    endcase
                end
            end else begin
                ram_done <= 1'b0;
                ram_dout <= $urandom;
            end
        end
    end

    // One complete access: predict from the model, drive, then observe until mfc
    task automatic do_access(input logic t_rw, input logic [1:0] t_size, input logic t_sx,
                             input logic [8:0] t_addr, input logic [31:0] t_wdata,
                             input int t_delay, input bit t_hang, input bit t_hold_req);
        bit          bad;
        bit          exp_fault;
        int          exp_lat;
        int          lat;
        bit          en_seen;
        int          ai;
        logic [31:0] v;
        ai  = int'(t_addr);
        bad = (t_size == 2'b11) || (t_size == 2'b01 && t_addr[0]) ||
              (t_size == 2'b10 && t_addr[1:0] != 2'b00);
        exp_fault = bad || t_hang;
        exp_lat   = bad ? 2 : (t_hang ? TO + 3 : 3 + t_delay);
        if (!exp_fault && t_rw) begin
            case (t_size)
                2'b00: begin
                    v = 32'(model_mem[ai]);
                    if (t_sx && v >= 128) v = v + 32'hFFFFFF00;
                end
                2'b01: begin
                    v = 32'(model_mem[ai]) + 256 * 32'(model_mem[ai+1]);
                    if (t_sx && v >= 32768) v = v + 32'hFFFF0000;
                end
                default: begin
                    v = 32'(model_mem[ai]) + (32'(model_mem[ai+1]) << 8) +
                        (32'(model_mem[ai+2]) << 16) + (32'(model_mem[ai+3]) << 24);
                end
            endcase
            exp_rdata = v;
        end
        if (!exp_fault && !t_rw) begin
            model_mem[ai] = t_wdata[7:0];
            if (t_size != 2'b00) model_mem[ai+1] = t_wdata[15:8];
            if (t_size == 2'b10) begin
                model_mem[ai+2] = t_wdata[23:16];
                model_mem[ai+3] = t_wdata[31:24];
            end
        end
        stub_delay = t_delay;
        stub_hang  = t_hang;
        @(negedge clk);
        req = 1'b1; rw = t_rw; size = t_size; sign_ext = t_sx; addr = t_addr; wdata = t_wdata;
        @(posedge clk);
        lat = 0;
        en_seen = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (!t_hold_req) req = 1'b0;
            rw = 1'($urandom); size = 2'($urandom); sign_ext = 1'($urandom);
            addr = 9'($urandom); wdata = $urandom;
            if (ram_enable) begin
                en_seen = 1'b1;
                check_val("ram_address", 32'(ram_address), 32'(t_addr & 9'h1FC));
                check_val("ram_a", 32'(ram_a), 32'(t_addr[1:0]));
                check_val("ram_mas", 32'(ram_mas), 32'(t_size));
                check_val("ram_rw", 32'(ram_rw), 32'(t_rw));
                check_val("ram_din", ram_din, t_wdata);
            end
            if (mfc) begin
                lat = c;
                req = 1'b0;
                break;
            end
            check_val("busy_during", 32'(busy), 32'd1);
        end
        check_val("latency", lat, exp_lat);
        check_val("fault", 32'(fault), 32'(exp_fault));
        check_val("rdata", rdata, exp_rdata);
        check_val("enable_in_resp", 32'(ram_enable), 32'd0);
        check_val("enable_seen", 32'(en_seen), 32'(!bad));
        @(negedge clk);
        check_val("mfc_after", 32'(mfc), 32'd0);
        check_val("busy_after", 32'(busy), 32'd0);
        check_val("fault_after", 32'(fault), 32'd0);
        stub_hang = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; rw = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_mfc", 32'(mfc), 32'd0);
        check_val("rst_fault", 32'(fault), 32'd0);
        check_val("rst_rdata", rdata, 32'd0);
        check_val("rst_enable", 32'(ram_enable), 32'd0);
        check_val("rst_address", 32'(ram_address), 32'd0);
        check_val("rst_din", ram_din, 32'd0);
        reset = 1'b0;

        // word store then load
        do_access(1'b0, 2'b10, 1'b0, 9'h004, 32'hDEADBEEF, 1, 1'b0, 1'b0);
        do_access(1'b1, 2'b10, 1'b0, 9'h004, 32'h0, 1, 1'b0, 1'b0);
        check_val("word_load_const", rdata, 32'hDEADBEEF);
        // signed / unsigned byte
        do_access(1'b0, 2'b00, 1'b0, 9'h009, 32'h12345680, 1, 1'b0, 1'b0);
        do_access(1'b1, 2'b00, 1'b1, 9'h009, 32'h0, 1, 1'b0, 1'b0);
        check_val("sbyte_const", rdata, 32'hFFFFFF80);
        do_access(1'b1, 2'b00, 1'b0, 9'h009, 32'h0, 2, 1'b0, 1'b0);
        check_val("ubyte_const", rdata, 32'h00000080);
        // signed halfword
        do_access(1'b0, 2'b01, 1'b0, 9'h00E, 32'hA5A58001, 1, 1'b0, 1'b0);
        do_access(1'b1, 2'b01, 1'b1, 9'h00E, 32'h0, 1, 1'b0, 1'b0);
        check_val("shalf_const", rdata, 32'hFFFF8001);
        // misaligned halfword, illegal size, misaligned word
        do_access(1'b1, 2'b01, 1'b0, 9'h003, 32'h0, 1, 1'b0, 1'b0);
        do_access(1'b0, 2'b11, 1'b0, 9'h010, 32'h11111111, 1, 1'b0, 1'b0);
        do_access(1'b1, 2'b10, 1'b0, 9'h006, 32'h0, 1, 1'b0, 1'b0);
        check_val("rdata_kept", rdata, 32'hFFFF8001);
        // timeout
        do_access(1'b1, 2'b10, 1'b0, 9'h000, 32'h0, 1, 1'b1, 1'b0);
        // req held high while busy: garbage requests must be ignored
        do_access(1'b1, 2'b10, 1'b0, 9'h004, 32'h0, 3, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("bp_no_mfc", 32'(mfc), 32'd0);
            check_val("bp_idle", 32'(busy), 32'd0);
        end

        // reset while in WAIT
        stub_hang = 1'b1;
        @(negedge clk);
        req = 1'b1; rw = 1'b1; size = 2'b10; sign_ext = 1'b0; addr = 9'h004; wdata = '0;
        @(posedge clk);
        repeat (3) @(negedge clk);
        req = 1'b0;
        check_val("wait_enable", 32'(ram_enable), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_val("rstw_enable", 32'(ram_enable), 32'd0);
        check_val("rstw_busy", 32'(busy), 32'd0);
        check_val("rstw_mfc", 32'(mfc), 32'd0);
        check_val("rstw_rdata", rdata, 32'd0);
        exp_rdata = 32'h0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_val("rstw_no_mfc", 32'(mfc), 32'd0);
        end
        stub_hang = 1'b0;

        // randomized accesses over a small window so loads hit earlier stores
        for (int i = 0; i < 60; i++) begin
            logic [8:0]  ra;
            logic [1:0]  rs;
            ra = 9'($urandom_range(0, 31));
            rs = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            do_access(1'($urandom), rs, 1'($urandom), ra, $urandom,
                      $urandom_range(1, 3), ($urandom_range(0, 11) == 0), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
